// File: rtl/logic_unit_pipe_if.sv
// Valid/ready bundle for the pipelined bitwise logic unit.
// The master drives operands and consumes results; the slave is the logic unit.
`timescale 1ns/1ps

interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  // Input side: operands offered by upstream
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // Output side: result presented to downstream
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic [2:0]       op_out;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, op_out
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, op_out
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit (NOT/AND/OR/XOR/NAND/NOR/XNOR/BUF).
// The result is computed at acceptance and carried through STAGES registered
// stages with full valid/ready backpressure; no bubble is needed between stages.
`timescale 1ns/1ps

module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_unit_pipe_if.slave bus,
  output logic             busy
);

  // Stage payload packs {op, zero, y} so one register array carries everything
  localparam int PW = WIDTH + 4;

  logic [STAGES-1:0] valid_r;
  logic [PW-1:0]     data_r     [STAGES];
  logic [PW-1:0]     src_data_s [STAGES];
  logic [STAGES:0]   src_valid_s;
  logic [STAGES-1:0] ready_s;
  logic [STAGES-1:0] advance_s;
  logic [STAGES-1:0] load_s;
  logic [WIDTH-1:0]  result_s;
  logic              result_zero_s;

  // Bitwise operation selected by the 3-bit opcode; b is ignored for NOT and BUF
  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       op_i,
    input logic [WIDTH-1:0] a_i,
    input logic [WIDTH-1:0] b_i
  );
    logic [WIDTH-1:0] r;
    case (op_i)
      3'd0:    r = ~a_i;
      3'd1:    r = a_i & b_i;
      3'd2:    r = a_i | b_i;
      3'd3:    r = a_i ^ b_i;
      3'd4:    r = ~(a_i & b_i);
      3'd5:    r = ~(a_i | b_i);
      3'd6:    r = ~(a_i ^ b_i);
      3'd7:    r = a_i;
      default: r = a_i;
    endcase
    return r;
  endfunction

  // Result and zero flag computed from the live inputs; only captured on accept
  always_comb begin
    result_s      = logic_op(bus.op, bus.a, bus.b);
    result_zero_s = (result_s == {WIDTH{1'b0}});
  end

  // Source of each stage: stage 0 takes the fresh result, stage k takes stage k-1
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign src_data_s[k] = {bus.op, result_zero_s, result_s};
    end else begin : g_next
      assign src_data_s[k] = data_r[k-1];
    end
  end

  assign src_valid_s = {valid_r, bus.in_valid};

  // Ready ripples back from out_ready: a stage can take data if empty or emptying
  always_comb begin
    logic ready_chain;
    advance_s   = {STAGES{1'b0}};
    ready_s     = {STAGES{1'b0}};
    load_s      = {STAGES{1'b0}};
    ready_chain = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      advance_s[k] = valid_r[k] & ready_chain;
      ready_s[k]   = ~valid_r[k] | advance_s[k];
      load_s[k]    = ready_s[k] & src_valid_s[k];
      ready_chain  = ready_s[k];
    end
  end

  // Stage registers: load wins over drain so a full pipe keeps flowing every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        data_r[k] <= {PW{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_s[k]) begin
          valid_r[k] <= 1'b1;
          data_r[k]  <= src_data_s[k];
        end else if (advance_s[k]) begin
          valid_r[k] <= 1'b0;
          data_r[k]  <= data_r[k];
        end else begin
          valid_r[k] <= valid_r[k];
          data_r[k]  <= data_r[k];
        end
      end
    end
  end

  // Outputs come straight from the last stage register
  assign bus.in_ready  = ready_s[0];
  assign bus.out_valid = valid_r[STAGES-1];
  assign bus.y         = data_r[STAGES-1][WIDTH-1:0];
  assign bus.zero      = data_r[STAGES-1][WIDTH];
  assign bus.op_out    = data_r[STAGES-1][WIDTH+3:WIDTH+1];
  assign busy          = |valid_r;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the single-bit combinational NOT gate.
- Applies one of eight bitwise operations (NOT, AND, OR, XOR, NAND, NOR, XNOR, BUF) to WIDTH-bit operands.
- Result travels through a STAGES-deep valid/ready pipeline with full backpressure.
- Used as the standard registered gate block in gate-level datapath experiments and their benches.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- STAGES, 2, pipeline depth in register stages (>=1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream presents op/a/b this cycle.
- in_ready  output  1  block accepts the input this cycle.
- op  input  3  opcode: 0 NOT a, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 BUF a.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for ops 0 and 7.
- out_valid  output  1  y/zero/op_out hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- y  output  WIDTH  result.
- zero  output  1  result is all zeros.
- op_out  output  3  opcode that produced y.
- busy  output  1  any pipeline stage holds valid data.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, effective immediately without a clock): all stage valid bits = 0; out_valid = 0; y = 0; zero = 0; op_out = 0; busy = 0.
- Reset mid-operation discards all in-flight results; none are emitted after release.
- First acceptance after release is possible on the first rising edge with rst_n high.
- Handshake: a transfer occurs on a rising edge where valid and ready are both high, on each side independently.
- Input: accept = in_valid & in_ready.
- Output: consume = out_valid & out_ready.
- Computation: done combinationally from op/a/b at acceptance and captured into stage 0 together with op and zero.
- Stages 1..STAGES-1 carry the captured result unchanged.
- Stage advance: stage k loads from stage k-1 (or from the input for k=0) when stage k is empty or stage k advances/consumes in the same cycle.
- in_ready = !valid[0] | advance[0]. It is combinational from out_ready through the chain; no bubble is required.
- Latency: with out_ready held high, a result accepted at edge N has out_valid high after edge N+STAGES-1, i.e. it is visible during cycle N+STAGES-1 and consumed at edge N+STAGES.
- Throughput: one result per cycle when out_ready is continuously high.
- Backpressure: while out_valid & !out_ready, y/zero/op_out hold stable.
- Backpressure fills stages behind the output. Once all STAGES stages are valid and out_ready is low, in_ready = 0.
- Capacity: STAGES results in flight; no loss and no reordering.
- Simultaneous consume on a full pipe with in_valid: accept in the same cycle; occupancy stays STAGES.
- in_valid low: no stage-0 load; existing data drains as downstream consumes.
- Data and opcode on unaccepted cycles are ignored.
- Width rules: all operations are purely bitwise over WIDTH bits; no carries.
- zero = (y == 0), registered alongside y.
- busy = OR of all stage valid bits.
- Inputs are sampled only on accepting edges. X on a/b while in_valid = 0 must not propagate to outputs.

Test Plan:
- Reset: drive rst_n low asynchronously while the pipe is full. Required: out_valid, busy, y and zero all go to 0 before the next clk edge; no stale result appears after release.
- Truth table (WIDTH=8, STAGES=2, out_ready=1): a=8'hA5, b=8'h0F, ops 0..7 back-to-back. Required: y sequence 5A, 05, AF, AA, FA, 50, 55, A5. Each result appears 1 cycle after acceptance, one per cycle, with op_out matching.
- Zero flag: op=3 (XOR), a=b=8'h3C. Required: y=00, zero=1. Then op=0 (NOT), a=8'hFF. Required: y=00, zero=1. Then op=2 (OR), a=00, b=01. Required: zero=0.
- Backpressure: out_ready=0 with 4 inputs offered. Required: exactly 2 accepted; in_ready falls to 0; y holds the first result stable. Raising out_ready then drains the results in order with no loss or duplication, and the remaining inputs are accepted one per cycle.
- Simultaneous consume/accept on a full pipe: out_ready=1 and in_valid=1. Required: in_ready=1 and occupancy stays 2 every cycle.
- Parameter sweep: WIDTH=1 with STAGES=1, and WIDTH=32 with STAGES=4, random op/a/b with random in_valid/out_ready. Required: a scoreboard reference model matches every y, zero and op_out; latency equals STAGES when out_ready=1.
